// File: rtl/demux12_2bits_flop.sv
// demux12_2bits_flop: 1:2 valid/ready demultiplexer with a registered FIFO per
// output channel, so a stall on one channel never blocks the other.
// Optional feature macro: DEMUX_COUNT_EN adds saturating per-channel pop
// counters on ports xfer_cnt0/xfer_cnt1.
`timescale 1ns/1ps
`ifndef DEMUX12_2BITS_FLOP
`define DEMUX12_2BITS_FLOP

module demux12_2bits_flop #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             selector,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out0,
  output logic             valid_out0,
  input  logic             ready0,
  output logic [WIDTH-1:0] data_out1,
  output logic             valid_out1,
  input  logic             ready1
`ifdef DEMUX_COUNT_EN
  ,
  output logic [7:0]       xfer_cnt0,
  output logic [7:0]       xfer_cnt1
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [1:0]            full;
  logic [1:0]            empty;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            sink_ready;
  logic [1:0][WIDTH-1:0] head;
`ifdef DEMUX_COUNT_EN
  logic [1:0][7:0]       xfer_cnt;
`endif

  // Input side: ready depends only on the selected channel's registered state,
  // so a full FIFO never admits a beat even if it pops on the same edge.
  assign sink_ready = {ready1, ready0};
  assign ready_out  = ~full[selector];
  assign push[0]    = valid_in & ready_out & ~selector;
  assign push[1]    = valid_in & ready_out & selector;
  assign pop        = ~empty & sink_ready;

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    state_t           state_q, state_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];

    // State, occupancy and pointer registers; pointers wrap modulo DEPTH.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
        state_q  <= ST_EMPTY;
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        state_q <= state_d;
        count_q <= count_d;
        if (push[ch]) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop[ch])  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end

    // Storage write on push.
    // NOTE: the data array has no reset; stale entries are invisible because data_out is gated by valid.
    always_ff @(posedge clk) begin
      if (push[ch]) mem[wr_ptr_q] <= data_in;
    end

    // Next-state: EMPTY/PARTIAL/FULL tracking the occupancy count.
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
        ST_EMPTY: begin
          if (push[ch]) begin
            state_d = ST_PARTIAL;
            count_d = CNT_ONE;
          end
        end
        ST_PARTIAL: begin
          if (push[ch] && !pop[ch]) begin
            count_d = count_q + CNT_ONE;
            if (count_q + CNT_ONE == CNT_MAX) state_d = ST_FULL;
          end else if (pop[ch] && !push[ch]) begin
            count_d = count_q - CNT_ONE;
            if (count_q == CNT_ONE) state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop[ch]) begin
            state_d = ST_PARTIAL;
            count_d = count_q - CNT_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          count_d = '0;
        end
      endcase
    end

    assign full[ch]  = (state_q == ST_FULL);
    assign empty[ch] = (state_q == ST_EMPTY);
    assign head[ch]  = empty[ch] ? '0 : mem[rd_ptr_q];

`ifdef DEMUX_COUNT_EN
    logic [7:0] xfer_q;

    // Pop counter, saturating at 255.
    always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L)                        xfer_q <= 8'd0;
      else if (pop[ch] && xfer_q != 8'hFF) xfer_q <= xfer_q + 8'd1;
    end

    assign xfer_cnt[ch] = xfer_q;
`endif
  end

  assign data_out0  = head[0];
  assign valid_out0 = ~empty[0];
  assign data_out1  = head[1];
  assign valid_out1 = ~empty[1];
`ifdef DEMUX_COUNT_EN
  assign xfer_cnt0  = xfer_cnt[0];
  assign xfer_cnt1  = xfer_cnt[1];
`endif

endmodule

`endif

// File: doc/demux12_2bits_flop.md
Name: demux12_2bits_flop

Overview:
- 1:2 demultiplexer for 2-bit data: the receiving end of the 2:1 2-bit multiplexor path. Splits one valid/ready input stream into two output streams, steered by `selector`.
- Each output channel has a small registered FIFO, so downstream stalls on one channel never block traffic to the other channel.
- Sits after the 2:1 mux in the gate-level mux/demux test structure, on the single clock domain.

Parameters:
- WIDTH, 2, data width of input and both outputs (>=1).
- DEPTH, 2, entries per output FIFO; power of two, >=2.

Ports:
- clk  in  1  rising-edge clock.
- reset_L  in  1  asynchronous active-low reset.
- data_in  in  WIDTH  input data.
- valid_in  in  1  input data valid.
- selector  in  1  destination: 0 -> channel 0, 1 -> channel 1.
- ready_out  out  1  block can accept the current beat.
- data_out0  out  WIDTH  channel 0 head data.
- valid_out0  out  1  channel 0 head valid.
- ready0  in  1  channel 0 sink ready.
- data_out1  out  WIDTH  channel 1 head data.
- valid_out1  out  1  channel 1 head valid.
- ready1  in  1  channel 1 sink ready.
- xfer_cnt0, xfer_cnt1  out  8  (only with DEMUX_COUNT_EN) transfers popped per channel.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - All FIFOs are emptied and both FSMs go to EMPTY.
  - valid_out0 = valid_out1 = 0; data_out0 = data_out1 = 0.
  - Counters are cleared.
  - Contents in flight at reset are discarded.
- Release: reset_L deassertion is sampled on clk. The first push can occur on the first rising edge with reset_L=1.
- Input handshake:
  - ready_out = NOT full[selector]. This is combinational from `selector` and registered FIFO state only; it does not depend on valid_in.
  - Push happens on a clk edge where valid_in && ready_out. data_in is written to the FIFO selected by `selector`.
  - A stalled source holds valid_in/data_in. `selector` may change while stalled; no beat is committed until the push edge.
- Output handshake, per channel N:
  - valid_outN = NOT emptyN.
  - data_outN = head entry while valid, else 0.
  - Pop happens on an edge where valid_outN && readyN.
  - valid_outN must not drop without a pop, and data_outN must be stable while valid_outN && !readyN.
- Latency: one cycle from the push edge to valid_outN=1 on an empty channel. No combinational input-to-output path.
- Per-channel FSM (states EMPTY, PARTIAL, FULL; count 0..DEPTH):
  - EMPTY:
    - push -> PARTIAL (count=1), or FULL when DEPTH=1, which is disallowed.
    - A pop in EMPTY is impossible (valid_outN=0).
  - PARTIAL:
    - push only -> count+1; goes to FULL when count reaches DEPTH.
    - pop only -> count-1; goes to EMPTY at 0.
    - push and pop together -> count unchanged, state held.
  - FULL:
    - ready_out=0 when that channel is selected, so there is no push.
    - pop -> PARTIAL.
    - No pass-through on full: a simultaneous pop on the same edge does not enable a push.
- Pointers: write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- Independence: channel 0 full/stalled has no effect on pushes to channel 1.
- Simultaneous events:
  - A push to one channel and a pop on the other on the same edge are both performed.
  - A push and pop on the same PARTIAL channel preserve order: the pop takes the old head, and the push lands at the tail.
- Order: FIFO order per channel; no ordering guarantee across channels.
- The macro guard for the module is DEMUX12_2BITS_FLOP.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - Ports xfer_cnt0/xfer_cnt1 exist.
  - Each is an 8-bit counter, incremented on every pop of its channel and saturating at 255.
  - Cleared asynchronously by reset_L.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream:
  - Stimulus: push 2'b10 to ch0, then assert reset_L=0 between clk edges.
  - Response: valid_out0=0 and data_out0=0 immediately, before the next edge; ready_out=1 after release.
- Single transfer:
  - Stimulus: selector=1, valid_in=1, data_in=2'b11 for one edge, with ready1=1.
  - Response: next cycle valid_out1=1, data_out1=2'b11; valid_out0 stays 0; the following cycle valid_out1=0.
- Fill/backpressure:
  - Stimulus: ready0=0, selector=0, push 2'b01, 2'b10, 2'b11.
  - Response: the third beat stalls (ready_out=0 while selector=0); switching selector=1 gives ready_out=1 and 2'b11 goes to ch1.
- Drain order and wrap:
  - Stimulus: DEPTH=2; push 0,1,2,3 to ch0 with ready0 toggling 1,0,1.
  - Response: data_out0 sequence is 0,1,2,3 with no loss or duplication; pointers wrap twice.
- Concurrent push/pop:
  - Stimulus: ch0 holds one entry 2'b01, ready0=1, push 2'b10 to ch0 on the same edge.
  - Response: 2'b01 is popped and next data_out0=2'b10, count stays 1.
- DEMUX_COUNT_EN:
  - Stimulus: 300 pops on ch1, 5 pops on ch0.
  - Response: xfer_cnt1=255 (saturated), xfer_cnt0=5.
